// File: rtl/n64adv_ctrl_responder_if.sv
// Joybus pad-emulation signal bundle: line sense/drive, pad word and command/status flags.
interface n64adv_ctrl_responder_if;
  logic        enable;
  logic        CTRL_i;
  logic [31:0] pad_data;
  logic        CTRL_OE;
  logic        rsp_busy;
  logic [7:0]  cmd_byte;
  logic        cmd_strobe;
  logic        err_strobe;

  modport slave (
    input  enable, CTRL_i, pad_data,
    output CTRL_OE, rsp_busy, cmd_byte, cmd_strobe, err_strobe
  );

  modport master (
    output enable, CTRL_i, pad_data,
    input  CTRL_OE, rsp_busy, cmd_byte, cmd_strobe, err_strobe
  );
endinterface

// File: rtl/n64adv_ctrl_responder.sv
// Controller-side joybus responder: decodes the console command on CTRL and answers
// STATUS (0x00/0xFF) or POLL (0x01) by pulling the open-drain line low via CTRL_OE.
module n64adv_ctrl_responder #(
  parameter int unsigned CLKS_PER_US = 4,
  parameter logic [23:0] STATUS_WORD = 24'h050002,
  parameter int unsigned TURN_US     = 2,
  parameter int unsigned IDLE_CLKS   = 255
) (
  input logic                    CLK_4M,
  input logic                    nSRST_4M,
  n64adv_ctrl_responder_if.slave bus
);

  localparam logic [7:0] TURN_LAST = 8'(TURN_US * CLKS_PER_US - 1);
  localparam logic [7:0] BIT_LAST  = 8'(4 * CLKS_PER_US - 1);
  localparam logic [7:0] LOW0      = 8'(3 * CLKS_PER_US);
  localparam logic [7:0] LOW1      = 8'(CLKS_PER_US);
  localparam logic [7:0] STOP_LAST = 8'(2 * CLKS_PER_US - 1);
  localparam logic [7:0] IDLE_MIN  = 8'(IDLE_CLKS);
  localparam logic [7:0] TMR_MAX   = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD_RD,
    ST_TURN,
    ST_TX,
    ST_TX_STOP
  } state_t;

  state_t      state_q, nxt_state;
  logic [2:0]  sync_q;
  logic [7:0]  tmr_q, nxt_tmr;
  logic [7:0]  low_cnt_q, nxt_low_cnt;
  logic [7:0]  rx_q, nxt_rx;
  logic [3:0]  bit_cnt_q, nxt_bit_cnt;
  logic [31:0] sh_q, nxt_sh;
  logic [5:0]  bits_left_q, nxt_bits_left;
  logic [7:0]  cmd_q, nxt_cmd;
  logic        oe_q, nxt_oe;
  logic        cmd_stb_q, nxt_cmd_stb;
  logic        err_stb_q, nxt_err_stb;

  logic        line, line_fall, line_rise;
  logic [7:0]  tmr_inc, low_len;
  logic [31:0] pad_rev;

  // sync_q[1:0] is the 2-flop synchronizer, sync_q[2] the history flop for edge detect
  assign line      = sync_q[1];
  assign line_fall = sync_q[2] & ~sync_q[1];
  assign line_rise = ~sync_q[2] & sync_q[1];
  assign tmr_inc   = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 8'd1;
  assign low_len   = sh_q[31] ? LOW1 : LOW0;
  // Both reply kinds shift out of sh_q[31]; POLL is loaded bit-reversed so bit0 goes first
  assign pad_rev   = {<<{bus.pad_data}};

  always_ff @(posedge CLK_4M) begin
    if (!nSRST_4M) begin
      state_q     <= ST_IDLE;
      sync_q      <= '1;
      tmr_q       <= '0;
      low_cnt_q   <= '0;
      rx_q        <= '0;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      bits_left_q <= '0;
      cmd_q       <= '0;
      oe_q        <= 1'b0;
      cmd_stb_q   <= 1'b0;
      err_stb_q   <= 1'b0;
    end else begin
      state_q     <= nxt_state;
      sync_q      <= {sync_q[1:0], bus.CTRL_i};
      tmr_q       <= nxt_tmr;
      low_cnt_q   <= nxt_low_cnt;
      rx_q        <= nxt_rx;
      bit_cnt_q   <= nxt_bit_cnt;
      sh_q        <= nxt_sh;
      bits_left_q <= nxt_bits_left;
      cmd_q       <= nxt_cmd;
      oe_q        <= nxt_oe;
      cmd_stb_q   <= nxt_cmd_stb;
      err_stb_q   <= nxt_err_stb;
    end
  end

  always_comb begin
    nxt_state     = state_q;
    nxt_tmr       = tmr_inc;
    nxt_low_cnt   = low_cnt_q;
    nxt_rx        = rx_q;
    nxt_bit_cnt   = bit_cnt_q;
    nxt_sh        = sh_q;
    nxt_bits_left = bits_left_q;
    nxt_cmd       = cmd_q;
    nxt_oe        = 1'b0;
    nxt_cmd_stb   = 1'b0;
    nxt_err_stb   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!line) nxt_tmr = '0;
        if (line_fall && bus.enable && (tmr_q >= IDLE_MIN)) begin
          nxt_state   = ST_CMD_RD;
          nxt_tmr     = '0;
          nxt_bit_cnt = '0;
        end
      end
      ST_CMD_RD: begin
        // Edges take priority over the saturation timeout
        if (line_fall) begin
          nxt_tmr = '0;
          if (bit_cnt_q == 4'd8) begin
            nxt_state = ST_IDLE;
          end else begin
            nxt_rx      = {rx_q[6:0], (low_cnt_q < tmr_q)};
            nxt_bit_cnt = bit_cnt_q + 4'd1;
          end
        end else if (line_rise) begin
          nxt_tmr     = '0;
          nxt_low_cnt = tmr_q;
          if (bit_cnt_q == 4'd8) begin
            nxt_cmd     = rx_q;
            nxt_cmd_stb = 1'b1;
            if (rx_q == 8'h00 || rx_q == 8'hFF) begin
              nxt_state     = ST_TURN;
              nxt_sh        = {STATUS_WORD, 8'h00};
              nxt_bits_left = 6'd24;
            end else if (rx_q == 8'h01) begin
              nxt_state     = ST_TURN;
              nxt_sh        = pad_rev;
              nxt_bits_left = 6'd32;
            end else begin
              nxt_state = ST_IDLE;
            end
          end
        end else if (tmr_q == TMR_MAX) begin
          nxt_state   = ST_IDLE;
          nxt_tmr     = '0;
          nxt_err_stb = 1'b1;
        end
      end
      ST_TURN: begin
        if (tmr_q == TURN_LAST) begin
          nxt_state = ST_TX;
          nxt_tmr   = '0;
          nxt_oe    = 1'b1;
        end
      end
      ST_TX: begin
        if ((tmr_q >= low_len + 8'd3) && !line) begin
          nxt_state   = ST_IDLE;
          nxt_tmr     = '0;
          nxt_err_stb = 1'b1;
        end else if (tmr_q == BIT_LAST) begin
          nxt_tmr = '0;
          nxt_oe  = 1'b1;
          if (bits_left_q == 6'd1) begin
            nxt_state = ST_TX_STOP;
          end else begin
            nxt_sh        = {sh_q[30:0], 1'b0};
            nxt_bits_left = bits_left_q - 6'd1;
          end
        end else begin
          nxt_oe = (tmr_inc < low_len);
        end
      end
      ST_TX_STOP: begin
        if (tmr_q == STOP_LAST) begin
          nxt_state = ST_IDLE;
          nxt_tmr   = '0;
        end else begin
          nxt_oe = 1'b1;
        end
      end
      default: begin
        nxt_state = ST_IDLE;
        nxt_tmr   = '0;
      end
    endcase
  end

  assign bus.CTRL_OE    = oe_q;
  assign bus.rsp_busy   = (state_q == ST_TURN) || (state_q == ST_TX) || (state_q == ST_TX_STOP);
  assign bus.cmd_byte   = cmd_q;
  assign bus.cmd_strobe = cmd_stb_q;
  assign bus.err_strobe = err_stb_q;

endmodule
